if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/if_id_reg.sv | 59 +++++
 rtl/if_stage.sv | 136 +++++++++++++
 tb/tb_if_stage.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the CPU front end.
//   - opcode encodings (top three bits of every instruction word)
//   - default instruction / program-counter widths
//   - instruction-fetch FSM state enum
//   - performance-counter width and a saturating increment helper
package cpu_pkg;

    localparam int unsigned INSTR_W_DEF = 16;
    localparam int unsigned PC_W_DEF    = 8;
    localparam int unsigned OPC_W       = 3;
    localparam int unsigned PERF_W      = 16;

    typedef enum logic [OPC_W-1:0] {
        OP_LW   = 3'b000,
        OP_SW   = 3'b001,
        OP_JMP  = 3'b010,
        OP_ADD  = 3'b011,
        OP_ADDI = 3'b100,
        OP_SUB  = 3'b101
    } opcode_e;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_FETCH = 2'd1,
        IF_FULL  = 2'd2
    } if_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (v == {PERF_W{1'b1}}) ? v : v + PERF_W'(1);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline slot holding one fetched instruction.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   load_i              capture instr_i/pc_i and mark the slot valid
//   clear_i             mark the slot empty (contents retained)
//   instr_i, pc_i       incoming instruction word and its address
//   valid_o, instr_o, pc_o  registered slot contents
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W    = PC_W_DEF,
    parameter int unsigned INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               clear_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [PC_W-1:0]    pc_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    pc_o
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc_q,    pc_d;

    // Load wins over clear; the FSM never raises both in one cycle.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (load_i) begin
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage. Requests one word at a time from
// instruction memory, parks it in the IF/ID slot until decode consumes
// it, then fetches the next word (or the jump target).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req, imem_addr        fetch request and word address (registered)
//   imem_rdata, imem_valid     fetched word, one-cycle response pulse
//   if_valid, if_instr, if_pc  IF/ID slot contents
//   if_opcode                  opcode field of if_instr (combinational)
//   id_ready                   decode consumes the slot this cycle
//   jmp, jmp_target            redirect applied on consume
//   perf_fetch, perf_stall     saturating counters, only when the
//                              IF_PERF_CNT_EN macro is defined
module if_stage
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W    = PC_W_DEF,
    parameter int unsigned INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc,
    output logic [OPC_W-1:0]   if_opcode,
    input  logic               id_ready,
    input  logic               jmp,
    input  logic [PC_W-1:0]    jmp_target
`ifdef IF_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]  perf_fetch,
    output logic [PERF_W-1:0]  perf_stall
`endif
);

    if_state_e        state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             req_q, req_d;
    logic             slot_load;
    logic             slot_clear;

    // Next-state, next-pc and slot control.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        slot_load  = 1'b0;
        slot_clear = 1'b0;
        unique case (state_q)
            IF_IDLE: begin
                state_d = IF_FETCH;
            end
            IF_FETCH: begin
                if (imem_valid) begin
                    slot_load = 1'b1;
                    pc_d      = pc_q + PC_W'(1);
                    state_d   = IF_FULL;
                end
            end
            IF_FULL: begin
                if (id_ready) begin
                    slot_clear = 1'b1;
                    state_d    = IF_FETCH;
                    if (jmp) begin
                        pc_d = jmp_target;
                    end
                end
            end
            default: begin
                state_d = IF_IDLE;
            end
        endcase
        // Request is registered from the next state so it is high for
        // exactly the cycles spent in FETCH.
        req_d = (state_d == IF_FETCH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IF_IDLE;
            pc_q    <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;

    if_id_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (slot_load),
        .clear_i (slot_clear),
        .instr_i (imem_rdata),
        .pc_i    (pc_q),
        .valid_o (if_valid),
        .instr_o (if_instr),
        .pc_o    (if_pc)
    );

    assign if_opcode = if_instr[INSTR_W-1 -: OPC_W];

`ifdef IF_PERF_CNT_EN
    logic [PERF_W-1:0] perf_fetch_q;
    logic [PERF_W-1:0] perf_stall_q;

    // Captured instructions and decode back-pressure cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (slot_load) begin
                perf_fetch_q <= sat_inc(perf_fetch_q);
            end
            if ((state_q == IF_FULL) && !id_ready) begin
                perf_stall_q <= sat_inc(perf_stall_q);
            end
        end
    end

    assign perf_fetch = perf_fetch_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed bench for if_stage. Inputs are driven and outputs
// sampled on the falling clock edge; expected values are hand-computed.
module tb_if_stage;
    import cpu_pkg::*;

    localparam int unsigned PC_W    = 8;
    localparam int unsigned INSTR_W = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_valid;
    logic               if_valid;
    logic [INSTR_W-1:0] if_instr;
    logic [PC_W-1:0]    if_pc;
    logic [2:0]         if_opcode;
    logic               id_ready;
    logic               jmp;
    logic [PC_W-1:0]    jmp_target;
`ifdef IF_PERF_CNT_EN
    logic [15:0]        perf_fetch;
    logic [15:0]        perf_stall;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic watch5 = 1'b0;
    logic saw5   = 1'b0;

    always #5 clk = ~clk;

    if_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_opcode  (if_opcode),
        .id_ready   (id_ready),
        .jmp        (jmp),
        .jmp_target (jmp_target)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch (perf_fetch),
        .perf_stall (perf_stall)
`endif
    );

    // Flags any fetch of word 5 while the jump test is armed.
    always @(negedge clk) begin
        if (watch5 && imem_req && (imem_addr == 8'h05)) saw5 <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Wait (bounded) for a request, check its address, answer in the same cycle.
    task automatic fetch_one(input string tag, input logic [15:0] data, input logic [7:0] exp_addr);
        int waited = 0;
        while (!imem_req && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_req"},  32'(imem_req), 32'd1);
        check({tag, "_addr"}, 32'(imem_addr), 32'(exp_addr));
        imem_valid = 1'b1;
        imem_rdata = data;
        @(negedge clk);
        imem_valid = 1'b0;
        imem_rdata = 16'h0000;
        check({tag, "_ifv"},   32'(if_valid), 32'd1);
        check({tag, "_instr"}, 32'(if_instr), 32'(data));
        check({tag, "_ifpc"},  32'(if_pc),    32'(exp_addr));
        check({tag, "_opc"},   32'(if_opcode), 32'(data[15:13]));
    endtask

    task automatic consume(input logic j, input logic [7:0] tgt);
        id_ready   = 1'b1;
        jmp        = j;
        jmp_target = tgt;
        @(negedge clk);
        id_ready   = 1'b0;
        jmp        = 1'b0;
        jmp_target = 8'h00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        imem_rdata = 16'h0000;
        imem_valid = 1'b0;
        id_ready   = 1'b0;
        jmp        = 1'b0;
        jmp_target = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check("rst_req",   32'(imem_req),  32'd0);
        check("rst_ifv",   32'(if_valid),  32'd0);
        check("rst_instr", 32'(if_instr),  32'd0);
        check("rst_ifpc",  32'(if_pc),     32'd0);
        check("rst_addr",  32'(imem_addr), 32'd0);

        // Release: cycle 1 idle, request in cycle 2, slot valid in cycle 3.
        rst_n = 1'b1;
        #1;
        check("c1_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        check("c2_req",  32'(imem_req),  32'd1);
        check("c2_addr", 32'(imem_addr), 32'd0);
        imem_valid = 1'b1;
        imem_rdata = 16'h6000;
        @(negedge clk);
        imem_valid = 1'b0;
        check("c3_ifv",   32'(if_valid),  32'd1);
        check("c3_opc",   32'(if_opcode), 32'(OP_ADD));
        check("c3_ifpc",  32'(if_pc),     32'd0);
        check("c3_instr", 32'(if_instr),  32'h6000);

        // Decode stalls for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_instr", 32'(if_instr), 32'h6000);
            check("stall_req",   32'(imem_req), 32'd0);
            check("stall_ifv",   32'(if_valid), 32'd1);
        end
`ifdef IF_PERF_CNT_EN
        check("perf_stall5", 32'(perf_stall), 32'd5);
        check("perf_fetch1", 32'(perf_fetch), 32'd1);
`endif

        // Stray response and a jump without consume while FULL: both ignored.
        imem_valid = 1'b1;
        imem_rdata = 16'hBEEF;
        jmp        = 1'b1;
        jmp_target = 8'h77;
        @(negedge clk);
        imem_valid = 1'b0;
        jmp        = 1'b0;
        jmp_target = 8'h00;
        check("full_vld_instr", 32'(if_instr), 32'h6000);
        check("full_vld_ifpc",  32'(if_pc),    32'd0);
        check("full_vld_req",   32'(imem_req), 32'd0);

        // Sequential fetches at 1..4.
        consume(1'b0, 8'h00);
        fetch_one("seq1", 16'h0001, 8'h01);
        consume(1'b0, 8'h00);
        fetch_one("seq2", 16'h2002, 8'h02);
        consume(1'b0, 8'h00);
        fetch_one("seq3", 16'h8003, 8'h03);
        consume(1'b0, 8'h00);
        fetch_one("seq4", 16'hA004, 8'h04);

        // Jump from the instruction at 4 to 0x20; word 5 must never be requested.
        watch5 = 1'b1;
        consume(1'b1, 8'h20);
        fetch_one("jmp20", 16'h4020, 8'h20);
        watch5 = 1'b0;
        check("no_fetch5", 32'(saw5), 32'd0);

        // Wrap: fetch at 0xFF, next sequential fetch at 0x00.
        consume(1'b1, 8'hFF);
        fetch_one("pcff", 16'h60FF, 8'hFF);
        consume(1'b0, 8'h00);
        fetch_one("wrap0", 16'h2100, 8'h00);

        // Reset during a fetch whose response arrives 3 cycles late.
        consume(1'b0, 8'h00);
        check("pre_rst_req",  32'(imem_req),  32'd1);
        check("pre_rst_addr", 32'(imem_addr), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req",  32'(imem_req), 32'd0);
        check("mid_rst_ifv",  32'(if_valid), 32'd0);
        check("mid_rst_ifpc", 32'(if_pc),    32'd0);
        check("mid_rst_addr", 32'(imem_addr), 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = 16'hFFFF;
        @(negedge clk);
        imem_valid = 1'b0;
        imem_rdata = 16'h0000;
        check("late_ifv",  32'(if_valid),  32'd0);
        check("late_req",  32'(imem_req),  32'd1);
        check("late_addr", 32'(imem_addr), 32'd0);
        fetch_one("restart", 16'h4005, 8'h00);
        check("restart_opc", 32'(if_opcode), 32'(OP_JMP));
`ifdef IF_PERF_CNT_EN
        check("perf_fetch_rst", 32'(perf_fetch), 32'd1);
        check("perf_stall_rst", 32'(perf_stall), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
